// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort engine index-pair generator.
package sort_pkg;

  localparam int unsigned SIZE_ADDR_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_BUBBLE = 1'b1
  } mode_e;

endpackage

// File: rtl/sort_pair_gen_if.sv
// Pair stream between the generator (master) and the compare/swap datapath (slave).
interface sort_pair_gen_if
  import sort_pkg::*;
#(
  parameter int unsigned SIZE_ADDR = SIZE_ADDR_DEFAULT
) ();

  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_ADDR-1:0] o_idx_a;
  logic [SIZE_ADDR-1:0] o_idx_b;
  logic [SIZE_ADDR-1:0] o_pass;
  logic                 o_row_last;
  logic                 i_swapped;

  modport master (
    output o_valid, o_idx_a, o_idx_b, o_pass, o_row_last,
    input  i_ready, i_swapped
  );

  modport slave (
    input  o_valid, o_idx_a, o_idx_b, o_pass, o_row_last,
    output i_ready, i_swapped
  );

endinterface

// File: rtl/sort_loop_cnt.sv
// Loadable up-counter with enable and a terminal compare against a one-bit-wider limit.
module sort_loop_cnt
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = SIZE_ADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH:0]   limit,
  output logic [WIDTH-1:0] cnt,
  output logic             at_limit
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  // Widened compare so a limit near 2^WIDTH cannot alias.
  assign at_limit = ({1'b0, cnt_q} == limit);

endmodule

// File: rtl/sort_pair_gen.sv
// Index-pair generator for in-place sort engines (SELECT triangular / BUBBLE adjacent loops).
// Define SORT_PAIR_EARLY_EXIT_EN to stop BUBBLE mode after a pass with no swaps.
module sort_pair_gen
  import sort_pkg::*;
#(
  parameter int unsigned SIZE_ADDR = SIZE_ADDR_DEFAULT,
  parameter int unsigned MODE_W    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [MODE_W-1:0]    i_mode,
  input  logic [SIZE_ADDR-1:0] i_num_elems,
  output logic                 o_busy,
  output logic                 o_done,
  sort_pair_gen_if.master      pair
);

  localparam int unsigned CW = SIZE_ADDR + 1;

  state_e               state_q, state_d;
  mode_e                mode_q;
  logic [SIZE_ADDR-1:0] n_q;
  logic                 done_q;
  logic [SIZE_ADDR-1:0] outer_cnt, inner_cnt, inner_load_val;
  logic [CW-1:0]        n_ext, outer_limit, inner_limit;
  logic                 outer_last, inner_last;
  logic                 start_go, start_bubble, run, accept, pass_end, sched_end, early_exit;
  logic                 outer_en, inner_load, inner_en;

  assign n_ext        = {1'b0, n_q};
  assign run          = (state_q == RUN);
  assign start_go     = (state_q == IDLE) && i_start && !i_abort;
  assign start_bubble = (i_mode == MODE_W'(MODE_BUBBLE));
  assign accept       = run && pair.i_ready && !i_abort;
  assign pass_end     = accept && inner_last;
  assign sched_end    = pass_end && (outer_last || early_exit);

  // Outer stops at N-2 in both modes; inner row end depends on the schedule shape.
  assign outer_limit = n_ext - CW'(2);
  assign inner_limit = (mode_q == MODE_BUBBLE) ? (n_ext - CW'(2) - {1'b0, outer_cnt})
                                               : (n_ext - CW'(1));

  assign outer_en   = pass_end && !sched_end;
  assign inner_load = start_go || outer_en;
  assign inner_en   = accept && !inner_last;

  // Inner restart value: first column of a new row/pass.
  always_comb begin
    inner_load_val = '0;
    if (start_go) begin
      inner_load_val = start_bubble ? '0 : SIZE_ADDR'(1);
    end else if (mode_q == MODE_SELECT) begin
      inner_load_val = outer_cnt + SIZE_ADDR'(2);
    end
  end

`ifdef SORT_PAIR_EARLY_EXIT_EN
  logic swap_seen_q;

  // Sticky per-pass swap flag; cleared at every pass start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      swap_seen_q <= 1'b0;
    end else if (start_go || pass_end) begin
      swap_seen_q <= 1'b0;
    end else if (accept) begin
      swap_seen_q <= swap_seen_q | pair.i_swapped;
    end
  end

  assign early_exit = (mode_q == MODE_BUBBLE) && !(swap_seen_q || pair.i_swapped);
`else
  logic unused_swapped;
  assign unused_swapped = pair.i_swapped;
  assign early_exit     = 1'b0;
`endif

  sort_loop_cnt #(
    .WIDTH (SIZE_ADDR)
  ) u_outer_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (start_go),
    .load_val ({SIZE_ADDR{1'b0}}),
    .en       (outer_en),
    .limit    (outer_limit),
    .cnt      (outer_cnt),
    .at_limit (outer_last)
  );

  sort_loop_cnt #(
    .WIDTH (SIZE_ADDR)
  ) u_inner_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (inner_load),
    .load_val (inner_load_val),
    .en       (inner_en),
    .limit    (inner_limit),
    .cnt      (inner_cnt),
    .at_limit (inner_last)
  );

  // Next-state logic; abort beats handshake and start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d = (i_num_elems < SIZE_ADDR'(2)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (sched_end) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched configuration and registered done pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_SELECT;
      n_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE) && !i_abort;
      if (start_go) begin
        n_q    <= i_num_elems;
        mode_q <= start_bubble ? MODE_BUBBLE : MODE_SELECT;
      end
    end
  end

  assign pair.o_valid    = run;
  assign pair.o_idx_a    = !run ? '0 : ((mode_q == MODE_BUBBLE) ? inner_cnt : outer_cnt);
  assign pair.o_idx_b    = !run ? '0 : ((mode_q == MODE_BUBBLE) ? inner_cnt + SIZE_ADDR'(1)
                                                                : inner_cnt);
  assign pair.o_pass     = run ? outer_cnt : '0;
  assign pair.o_row_last = run && inner_last;
  assign o_busy          = (state_q != IDLE);
  assign o_done          = done_q;

endmodule

// File: tb/tb_sort_pair_gen.sv
// Self-checking bench for sort_pair_gen: queue-based schedule model plus literal pins.
module tb_sort_pair_gen;
  import sort_pkg::*;

  localparam int unsigned SA = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [0:0]    mode  = 1'b0;
  logic [SA-1:0] num   = '0;
  logic          busy, done;

  sort_pair_gen_if #(.SIZE_ADDR(SA)) bus ();

  sort_pair_gen #(
    .SIZE_ADDR (SA),
    .MODE_W    (1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_mode      (mode),
    .i_num_elems (num),
    .o_busy      (busy),
    .o_done      (done),
    .pair        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int p;
    bit last;
  } pair_t;

  pair_t exp_q[$];
  pair_t acc_q[$];

  int checks = 0, errors = 0;
  bit model_on = 0, m_running = 0, m_in_done = 0, m_done_out = 0, m_rst_seen = 0, m_swap = 0;
  int m_mode = 0;
  int start_cyc = 0, done_cyc = -1, done_cnt = 0, acc_cnt = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Full schedule straight from the loop definitions.
  function automatic void build(int md, int n);
    exp_q.delete();
    if (md == 0) begin
      for (int i = 0; i <= n - 2; i++)
        for (int j = i + 1; j <= n - 1; j++)
          exp_q.push_back('{i, j, i, (j == n - 1)});
    end else begin
      for (int p = 0; p <= n - 2; p++)
        for (int j = 0; j <= n - 2 - p; j++)
          exp_q.push_back('{j, j + 1, p, (j == n - 2 - p)});
    end
  endfunction

  // Compare outputs against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin : cmp
    pair_t h;
    bit    nd;
    if (model_on) begin
      chk("valid", bus.o_valid, m_running);
      if (m_rst_seen) begin
        chk("rst_idx_a", bus.o_idx_a, 0);
        chk("rst_idx_b", bus.o_idx_b, 0);
        chk("rst_pass", bus.o_pass, 0);
        chk("rst_row_last", bus.o_row_last, 0);
      end
      if (m_running && exp_q.size() > 0) begin
        chk("idx_a", bus.o_idx_a, exp_q[0].a);
        chk("idx_b", bus.o_idx_b, exp_q[0].b);
        chk("pass", bus.o_pass, exp_q[0].p);
        chk("row_last", bus.o_row_last, exp_q[0].last);
      end
      chk("done", done, m_done_out);
      chk("busy", busy, m_running || m_in_done);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.o_valid && bus.i_ready && !abort && rst_n) begin
        acc_q.push_back('{int'(bus.o_idx_a), int'(bus.o_idx_b), int'(bus.o_pass),
                          bus.o_row_last});
        acc_cnt++;
      end

      m_rst_seen = 0;
      if (!rst_n) begin
        m_running  = 0;
        m_in_done  = 0;
        m_done_out = 0;
        m_rst_seen = 1;
        exp_q.delete();
      end else begin
        nd = m_in_done && !abort;
        if (m_in_done) begin
          m_in_done = 0;
        end else if (m_running) begin
          if (abort) begin
            m_running = 0;
            exp_q.delete();
          end else if (bus.i_ready) begin
            h = exp_q.pop_front();
`ifdef SORT_PAIR_EARLY_EXIT_EN
            m_swap = m_swap | bus.i_swapped;
            if (h.last) begin
              if (m_mode == 1 && !m_swap) exp_q.delete();
              m_swap = 0;
            end
`endif
            if (exp_q.size() == 0) begin
              m_running = 0;
              m_in_done = 1;
            end
          end
        end else if (start && !abort) begin
          m_mode    = int'(mode);
          m_swap    = 0;
          start_cyc = cyc;
          build(int'(mode), int'(num));
          if (exp_q.size() == 0) m_in_done = 1;
          else m_running = 1;
        end
        m_done_out = nd;
      end
    end
  end

  // rp: 0 ready=1, 1 ready 1,0,0 repeating, 2 random. sp: 0 none, 1 pass 0 only, 2 random.
  task automatic run(input int md, input int n, input int rp, input int sp, input int ab);
    int k;
    bit aborted;
    int budget;
    budget = 3 * n * n + 40;
    @(posedge clk);
    #1;
    acc_q.delete();
    acc_cnt     = 0;
    mode        = md[0];
    num         = n[SA-1:0];
    start       = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    aborted = 0;
    for (k = 0; k < budget; k++) begin
      if (!m_running && !m_in_done) break;
      case (rp)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = (k % 3 == 0);
        default: bus.i_ready = 1'($urandom_range(0, 1));
      endcase
      case (sp)
        1:       bus.i_swapped = (acc_cnt < n - 1);
        2:       bus.i_swapped = 1'($urandom_range(0, 1));
        default: bus.i_swapped = 1'b0;
      endcase
      abort = (ab >= 0 && !aborted && acc_cnt == ab);
      if (abort) aborted = 1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
    chk("run_timeout", m_running || m_in_done, 0);
    bus.i_ready   = 1'b0;
    bus.i_swapped = 1'b0;
    @(negedge clk);
    #1;
  endtask

  int d0;
  int sel4_a[6]    = '{0, 0, 0, 1, 1, 2};
  int sel4_b[6]    = '{1, 2, 3, 2, 3, 3};
  int four_last[6] = '{0, 0, 1, 0, 1, 1};
  int bub4_a[6]    = '{0, 1, 2, 0, 1, 0};
  int bub4_p[6]    = '{0, 0, 0, 1, 1, 2};

  initial begin
    bus.i_ready   = 1'b0;
    bus.i_swapped = 1'b0;
    repeat (2) @(posedge clk);
    #1 model_on = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // SELECT N=4
    d0 = done_cnt;
    run(0, 4, 0, 0, -1);
    chk("sel4_count", acc_q.size(), 6);
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      chk("sel4_a", acc_q[i].a, sel4_a[i]);
      chk("sel4_b", acc_q[i].b, sel4_b[i]);
      chk("sel4_last", acc_q[i].last, four_last[i]);
    end
    chk("sel4_done_cnt", done_cnt - d0, 1);
    chk("sel4_busy_after", busy, 0);

    // BUBBLE N=4
    run(1, 4, 0, 0, -1);
    chk("bub4_count", acc_q.size(), 6);
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      chk("bub4_a", acc_q[i].a, bub4_a[i]);
      chk("bub4_b", acc_q[i].b, bub4_a[i] + 1);
      chk("bub4_pass", acc_q[i].p, bub4_p[i]);
      chk("bub4_last", acc_q[i].last, four_last[i]);
    end

    // Backpressure SELECT N=3
    run(0, 3, 1, 0, -1);
    chk("bp_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("bp_p0", acc_q[0].a * 16 + acc_q[0].b, 1);
      chk("bp_p1", acc_q[1].a * 16 + acc_q[1].b, 2);
      chk("bp_p2", acc_q[2].a * 16 + acc_q[2].b, 16 * 1 + 2);
    end

    // N=0 and N=1
    for (int n = 0; n < 2; n++) begin
      d0 = done_cnt;
      run(n, n, 0, 0, -1);
      chk("small_count", acc_q.size(), 0);
      chk("small_done_cnt", done_cnt - d0, 1);
      chk("small_done_delay", done_cyc - start_cyc, 2);
    end

    // N=255 full SELECT schedule
    run(0, 255, 0, 0, -1);
    chk("big_count", acc_q.size(), 32385);
    if (acc_q.size() > 0) begin
      chk("big_last_a", acc_q[acc_q.size() - 1].a, 253);
      chk("big_last_b", acc_q[acc_q.size() - 1].b, 254);
    end

    // Abort after the 2nd accept
    d0 = done_cnt;
    run(0, 5, 0, 0, 2);
    chk("abort_count", acc_q.size(), 2);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_busy", busy, 0);

    // Reset mid-run, then restart
    @(posedge clk);
    #1;
    mode        = 1'b0;
    num         = SA'(6);
    start       = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", bus.o_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst_n       = 1'b1;
    bus.i_ready = 1'b0;
    run(0, 3, 0, 0, -1);
    chk("restart_count", acc_q.size(), 3);
    if (acc_q.size() > 0) begin
      chk("restart_a", acc_q[0].a, 0);
      chk("restart_b", acc_q[0].b, 1);
    end

    // Early exit: BUBBLE N=5, swaps only in pass 0
    run(1, 5, 0, 1, -1);
`ifdef SORT_PAIR_EARLY_EXIT_EN
    chk("early_count", acc_q.size(), 7);
    if (acc_q.size() > 0) chk("early_last_pass", acc_q[acc_q.size() - 1].p, 1);
`else
    chk("early_count", acc_q.size(), 10);
    if (acc_q.size() > 0) chk("early_last_pass", acc_q[acc_q.size() - 1].p, 3);
`endif

    // Randomised runs
    for (int r = 0; r < 30; r++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      run(int'($urandom_range(0, 1)), int'($urandom_range(0, 12)), 2, 2, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
